// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Conditions a raw, bouncy level input (switch or button) into a clean,
// registered level. A change on the input is accepted only after STABLE_CNT
// consecutive samples all differ from the current output. Any sample that
// matches the output during qualification throws away all progress.
//
// Parameters:
//   STABLE_CNT : consecutive differing samples needed to change q (>= 2)
//   CNT_W      : stability counter width (STABLE_CNT-1 must fit)
//   INIT_VAL   : reset value of q and of the synchronizer flops
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (overrides everything)
//   d_raw in   raw bouncy input level
//   q     out  debounced level, registered
//   q_b   out  registered complement of q
//   rise  out  one-cycle strobe in the cycle after q commits 0->1
//   fall  out  one-cycle strobe in the cycle after q commits 1->0
//   busy  out  registered decode of state==CHECK; this is the FSM's
//              externally visible state (STABLE=0, CHECK=1)
//
// Build option:
//   DEBOUNCE_SYNC_EN  when defined, d_raw passes through a two-flop
//                     synchronizer first (two extra cycles of latency).
//                     When undefined, d_raw must already be synchronous.
//
// Handshake: none. rise/fall are unconditional strobes; a consumer that
// needs them must sample them on the very next clock edge.
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int   STABLE_CNT = 1000,
    parameter int   CNT_W      = 16,
    parameter logic INIT_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic q_b,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    // Counter value at which the STABLE_CNT-th differing sample is seen.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    generate
        if (STABLE_CNT < 2) begin : g_bad_stable_cnt
            $error("switch_debouncer: STABLE_CNT must be >= 2");
        end
        if ((CNT_W < 31) && ((STABLE_CNT - 1) >= (1 << CNT_W))) begin : g_bad_cnt_w
            $error("switch_debouncer: CNT_W too narrow for STABLE_CNT-1");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;      // sample seen by the FSM

`ifdef DEBOUNCE_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= INIT_VAL;
            sync2 <= INIT_VAL;
        end else begin
            sync1 <= d_raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = d_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
            q     <= INIT_VAL;
            q_b   <= ~INIT_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // Strobes are high only in the cycle directly after a commit.
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (s != q) begin
                        // This sample is the first differing one.
                        state <= CHECK;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                CHECK: begin
                    if (s == q) begin
                        // Glitch: no partial credit is kept.
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        // STABLE_CNT-th consecutive differing sample: commit.
                        q     <= s;
                        q_b   <= ~s;
                        rise  <= s;
                        fall  <= ~s;
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Bench for switch_debouncer with STABLE_CNT=4, INIT_VAL=0. Directed cycle
// tables (or, in a DEBOUNCE_SYNC_EN build, a hand sequence for the
// synchronizer latency) followed by randomized runs checked against a
// window-based reference model: q flips to s when the last STABLE_CNT
// samples since the last reset/commit all differ from q.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int   N        = 4;
    localparam logic INIT_VAL = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_raw = 1'b0;
    logic q, q_b, rise, fall, busy;

    always #5 clk = ~clk;

    switch_debouncer #(
        .STABLE_CNT(N),
        .CNT_W     (3),
        .INIT_VAL  (INIT_VAL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_raw(d_raw),
        .q    (q),
        .q_b  (q_b),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    // Expected {q, q_b, rise, fall, busy} after each clock edge.
    logic [4:0] exp_q[$];

    task automatic check(input string name, input logic [4:0] got);
        logic [4:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected value queued, got=%b", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL %s @%0t: got {q,q_b,rise,fall,busy}=%b required=%b",
                         name, $time, got, exp);
            end
        end
    endtask

    // ---------------- reference model ----------------
    logic m_q = INIT_VAL;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic m_busy = 1'b0;
    logic hist[$];   // samples since last reset/commit, newest at back
    logic pipe[$];   // synchronizer delay line, oldest at front

    function automatic void model_reset();
        m_q    = INIT_VAL;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
        hist.delete();
        pipe.delete();
        pipe.push_back(INIT_VAL);
        pipe.push_back(INIT_VAL);
    endfunction

    function automatic void model_edge(input logic r, input logic d);
        logic s;
        logic all_diff;
        if (r) begin
            model_reset();
            return;
        end
`ifdef DEBOUNCE_SYNC_EN
        s = pipe.pop_front();
        pipe.push_back(d);
`else
        s = d;
`endif
        hist.push_back(s);
        if (hist.size() > N) void'(hist.pop_front());
        all_diff = (hist.size() == N);
        foreach (hist[i]) if (hist[i] == m_q) all_diff = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (all_diff) begin
            m_q    = s;
            m_rise = s;
            m_fall = ~s;
            m_busy = 1'b0;
            hist.delete();
        end else begin
            m_busy = (s != m_q);
        end
    endfunction

    function automatic logic [4:0] model_out();
        return {m_q, ~m_q, m_rise, m_fall, m_busy};
    endfunction

    // ---------------- driver ----------------
    // Apply inputs, take one clock edge, then settle 1 time unit before
    // any sampling.
    task automatic step(input logic r, input logic d);
        rst   = r;
        d_raw = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       r;
        logic       d;
        logic [4:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string tag, input logic r, input logic d,
                                input logic eq, input logic er, input logic ef,
                                input logic eb);
        vec_t v;
        v.r   = r;
        v.d   = d;
        v.exp = {eq, ~eq, er, ef, eb};
        v.tag = tag;
        vecs.push_back(v);
    endfunction

    initial begin
        int lvl, len;
        logic r;

        model_reset();

`ifndef DEBOUNCE_SYNC_EN
        //   tag         rst d   q ri fa busy
        // Reset with d_raw=1, then qualification right after release
        add("rst_hold",   1, 1,  0, 0, 0, 0);
        add("rst_hold",   1, 1,  0, 0, 0, 0);
        add("rst_rel",    0, 1,  0, 0, 0, 1);
        add("rst_rel",    0, 1,  0, 0, 0, 1);
        add("rst_rel",    0, 1,  0, 0, 0, 1);
        add("rst_rel_q",  0, 1,  1, 1, 0, 0);
        add("rst_rel_q",  0, 1,  1, 0, 0, 0);
        // Clean fall
        add("fall",       0, 0,  1, 0, 0, 1);
        add("fall",       0, 0,  1, 0, 0, 1);
        add("fall",       0, 0,  1, 0, 0, 1);
        add("fall_q",     0, 0,  0, 0, 1, 0);
        add("fall_q",     0, 0,  0, 0, 0, 0);
        // Glitch rejection: 3 on / 1 off, three times
        for (int k = 0; k < 3; k++) begin
            add("glitch",     0, 1,  0, 0, 0, 1);
            add("glitch",     0, 1,  0, 0, 0, 1);
            add("glitch",     0, 1,  0, 0, 0, 1);
            add("glitch_off", 0, 0,  0, 0, 0, 0);
        end
        // Clean rise
        add("rise",       0, 1,  0, 0, 0, 1);
        add("rise",       0, 1,  0, 0, 0, 1);
        add("rise",       0, 1,  0, 0, 0, 1);
        add("rise_q",     0, 1,  1, 1, 0, 0);
        add("rise_q",     0, 1,  1, 0, 0, 0);
        // Back to 0
        add("fall2",      0, 0,  1, 0, 0, 1);
        add("fall2",      0, 0,  1, 0, 0, 1);
        add("fall2",      0, 0,  1, 0, 0, 1);
        add("fall2_q",    0, 0,  0, 0, 1, 0);
        add("fall2_q",    0, 0,  0, 0, 0, 0);
        // Reset mid-CHECK aborts; full qualification afterwards
        add("midrst",     0, 1,  0, 0, 0, 1);
        add("midrst",     0, 1,  0, 0, 0, 1);
        add("midrst_rst", 1, 1,  0, 0, 0, 0);
        add("midrst_req", 0, 1,  0, 0, 0, 1);
        add("midrst_req", 0, 1,  0, 0, 0, 1);
        add("midrst_req", 0, 1,  0, 0, 0, 1);
        add("midrst_q",   0, 1,  1, 1, 0, 0);
        add("midrst_q",   0, 1,  1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].d);
            exp_q.push_back(vecs[i].exp);
            check(vecs[i].tag, {q, q_b, rise, fall, busy});
        end
`else
        // Synchronizer build: two extra cycles before the FSM sees d_raw.
        step(1, 0);
        exp_q.push_back(5'b01000);
        check("sync_rst", {q, q_b, rise, fall, busy});
        step(1, 0);
        exp_q.push_back(5'b01000);
        check("sync_rst", {q, q_b, rise, fall, busy});
        // d_raw 0->1 in cycle 0; q/rise visible in cycle 6 (after edge 5).
        for (int c = 0; c < 7; c++) begin
            step(0, 1);
            if (c == 5)                exp_q.push_back(5'b10100);
            else if (c == 6)           exp_q.push_back(5'b10000);
            else if (c >= 2 && c <= 4) exp_q.push_back(5'b01001);
            else                       exp_q.push_back(5'b01000);
            check("sync_rise", {q, q_b, rise, fall, busy});
        end
        // A pulse shorter than STABLE_CNT samples never changes q.
        for (int c = 0; c < 9; c++) begin
            step(0, (c < 3) ? 1'b0 : 1'b1);
            if (c >= 2 && c <= 4) exp_q.push_back(5'b10001);
            else                  exp_q.push_back(5'b10000);
            check("sync_pulse", {q, q_b, rise, fall, busy});
        end
`endif

        // ---------------- randomized runs vs model ----------------
        step(1, 0);
        exp_q.push_back(model_out());
        check("rand_rst", {q, q_b, rise, fall, busy});
        for (int k = 0; k < 300; k++) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 7);
            for (int c = 0; c < len; c++) begin
                r = ($urandom_range(0, 49) == 0);
                step(r, lvl[0]);
                exp_q.push_back(model_out());
                check("rand", {q, q_b, rise, fall, busy});
            end
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
